// File: rtl/button_ctrl.sv
// Push-button front end: three synchronize+debounce channels feeding registered
// start/stop pulses and a mode toggle level for the downstream run-control FSM.
`timescale 1ns/1ps
module button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic xrst,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_mode,
  output logic start,
  output logic stop,
  output logic mode
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel order: bit 0 = start, bit 1 = stop, bit 2 = mode.
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_mode, btn_stop, btn_start};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic          s1_q, s1_d;
      logic          s2_q, s2_d;
      logic          db_q, db_d;
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        s1_d  = btn_raw[gi];
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
          if (cnt_q == CNT_LAST) begin
            db_d = s2_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          db_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1_q  <= s1_d;
          s2_q  <= s2_d;
          db_q  <= db_d;
          cnt_q <= cnt_d;
        end
      end

      // Press is the debounced 0->1 transition being committed on this edge.
      assign press[gi] = db_d & ~db_q;
    end
  endgenerate

  logic start_q, start_d;
  logic stop_q,  stop_d;
  logic mode_q,  mode_d;

  // A coincident start press loses to stop and is discarded outright.
  always_comb begin
    stop_d  = press[1];
    start_d = press[0] & ~press[1];
    mode_d  = mode_q ^ press[2];
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
      mode_q  <= mode_d;
    end
  end

  assign start = start_q;
  assign stop  = stop_q;
  assign mode  = mode_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl (DEBOUNCE_CYCLES=4): vector table plus a
// hand-written reset-during-debounce sequence.
`timescale 1ns/1ps
module tb_button_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic btn_start = 1'b0;
  logic btn_stop = 1'b0;
  logic btn_mode = 1'b0;
  logic start, stop, mode;

  always #50 clk = ~clk;

  button_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .xrst      (xrst),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_mode  (btn_mode),
    .start     (start),
    .stop      (stop),
    .mode      (mode)
  );

  typedef struct packed {
    logic [7:0] phase;
    logic       xr;
    logic       bs;
    logic       bp;
    logic       bm;
    logic       es;
    logic       ep;
    logic       em;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input int n, input logic [7:0] ph, input logic xr,
                     input logic bs, input logic bp, input logic bm,
                     input logic es, input logic ep, input logic em);
    vec_t v;
    v.phase = ph; v.xr = xr; v.bs = bs; v.bp = bp; v.bm = bm;
    v.es = es; v.ep = ep; v.em = em;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [2:0] exp);
    logic [2:0] act;
    act = {start, stop, mode};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s #%0d: {start,stop,mode} got %b required %b", name, idx, act, exp);
    end else begin
      $display("ok   %s #%0d: {start,stop,mode} = %b", name, idx, act);
    end
  endtask

  // Inputs change 1 ns after an edge, so they are sampled by the next edge.
  task automatic drive_edge(input logic xr, input logic bs, input logic bp, input logic bm);
    xrst = xr; btn_start = bs; btn_stop = bp; btn_mode = bm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    logic [2:0] pat;

    // Phase 0: reset held with buttons toggling.
    for (int i = 0; i < 8; i++) begin
      pat = 3'(i);
      add(1, 8'd0, 1'b0, pat[0], pat[1], pat[2], 1'b0, 1'b0, 1'b0);
    end
    // Phase 1: idle after reset release.
    add(20, 8'd1, 1'b1, 0, 0, 0, 0, 0, 0);
    // Phase 2: clean start press, pulse on the 6th edge (capture + 5).
    add(5,  8'd2, 1'b1, 1, 0, 0, 0, 0, 0);
    add(1,  8'd2, 1'b1, 1, 0, 0, 1, 0, 0);
    add(4,  8'd2, 1'b1, 1, 0, 0, 0, 0, 0);
    add(12, 8'd2, 1'b1, 0, 0, 0, 0, 0, 0);
    // Phase 3: bouncing stop 1,0,1,1,0 then steady 1 from row 5 -> pulse row 10.
    add(1,  8'd3, 1'b1, 0, 1, 0, 0, 0, 0);
    add(1,  8'd3, 1'b1, 0, 0, 0, 0, 0, 0);
    add(2,  8'd3, 1'b1, 0, 1, 0, 0, 0, 0);
    add(1,  8'd3, 1'b1, 0, 0, 0, 0, 0, 0);
    add(5,  8'd3, 1'b1, 0, 1, 0, 0, 0, 0);
    add(1,  8'd3, 1'b1, 0, 1, 0, 0, 1, 0);
    add(4,  8'd3, 1'b1, 0, 1, 0, 0, 0, 0);
    add(12, 8'd3, 1'b1, 0, 0, 0, 0, 0, 0);
    // Phase 4: 3-cycle glitch reaches count D-1 but never commits.
    add(3,  8'd4, 1'b1, 0, 1, 0, 0, 0, 0);
    add(12, 8'd4, 1'b1, 0, 0, 0, 0, 0, 0);
    // Phase 5: simultaneous start+stop -> stop only; then start alone.
    add(5,  8'd5, 1'b1, 1, 1, 0, 0, 0, 0);
    add(1,  8'd5, 1'b1, 1, 1, 0, 0, 1, 0);
    add(4,  8'd5, 1'b1, 1, 1, 0, 0, 0, 0);
    add(12, 8'd5, 1'b1, 0, 0, 0, 0, 0, 0);
    add(5,  8'd5, 1'b1, 1, 0, 0, 0, 0, 0);
    add(1,  8'd5, 1'b1, 1, 0, 0, 1, 0, 0);
    add(4,  8'd5, 1'b1, 1, 0, 0, 0, 0, 0);
    add(12, 8'd5, 1'b1, 0, 0, 0, 0, 0, 0);
    // Phase 6: three mode presses, 12 cycles pressed / 12 released.
    m = 1'b0;
    for (int p = 0; p < 3; p++) begin
      add(5,  8'd6, 1'b1, 0, 0, 1, 0, 0, m);
      m = ~m;
      add(7,  8'd6, 1'b1, 0, 0, 1, 0, 0, m);
      add(12, 8'd6, 1'b1, 0, 0, 0, 0, 0, m);
    end

    foreach (vecs[i]) begin
      drive_edge(vecs[i].xr, vecs[i].bs, vecs[i].bp, vecs[i].bm);
      check($sformatf("vec_ph%0d", vecs[i].phase), i,
            {vecs[i].es, vecs[i].ep, vecs[i].em});
    end

    // Reset two counts into a start debounce; mode is 1 here.
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b1, 1'b1, 1'b0, 1'b0);
      check("pre_rst", i, 3'b001);
    end
    xrst = 1'b0;
    #1;
    check("async_rst", 0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 1'b1, 1'b0, 1'b0);
      check("in_rst", i, 3'b000);
    end
    // Button still held at release: first post-reset edge is the capture.
    for (int i = 0; i < 12; i++) begin
      drive_edge(1'b1, 1'b1, 1'b0, 1'b0);
      check("post_rst", i, (i == D + 1) ? 3'b100 : 3'b000);
    end
    for (int i = 0; i < 12; i++) begin
      drive_edge(1'b1, 1'b0, 1'b0, 1'b0);
      check("post_rel", i, 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
